// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD frame-buffer path: arbiter FSM states,
// requester identifiers and the default frame-buffer extent.
package lcd_pkg;

    localparam logic [12:0] FB_LAST_DEF = 13'h12BF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RDW,
        ST_ACK,
        ST_GAP
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_REF,
        REQ_CAP,
        REQ_HST
    } req_id_t;

endpackage

// File: rtl/fb_arb_pri.sv
// Fixed-priority grant select (ref > cap > hst) with a host starvation
// override driven by a saturating host wait counter.
module fb_arb_pri
    import lcd_pkg::*;
#(
    parameter int HST_MAX = 8
)(
    input  logic    clk,
    input  logic    rst,
    input  logic    arb_en,
    input  logic    ref_req,
    input  logic    cap_req,
    input  logic    hst_req,
    output req_id_t grant
);

    localparam int            CW        = $clog2(HST_MAX + 1);
    localparam logic [CW-1:0] HST_MAX_C = CW'(HST_MAX);

    logic [CW-1:0] wait_cnt;
    logic          starved;

    assign starved = (wait_cnt >= HST_MAX_C);

    always_comb begin
        grant = REQ_NONE;
        if (arb_en) begin
            if (hst_req && starved) begin
                grant = REQ_HST;
            end else if (ref_req) begin
                grant = REQ_REF;
            end else if (cap_req) begin
                grant = REQ_CAP;
            end else if (hst_req) begin
                grant = REQ_HST;
            end
        end
    end

    // Counts every cycle the host is kept waiting, including busy cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!hst_req || grant == REQ_HST) begin
            wait_cnt <= '0;
        end else if (wait_cnt != HST_MAX_C) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fb_port_arb.sv
// Frame-buffer port arbiter: shares one single-port SRAM between capture
// writes, host accesses and refresh reads, one SRAM access per grant.
module fb_port_arb
    import lcd_pkg::*;
#(
    parameter int            AW      = 13,
    parameter int            DW      = 8,
    parameter logic [AW-1:0] FB_LAST = FB_LAST_DEF,
    parameter int            RD_LAT  = 1,
    parameter int            HST_MAX = 8
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_wrreq,
    output logic          cap_wrack,
    input  logic [AW-1:0] cap_waddr,
    input  logic [DW-1:0] cap_wdata,
    input  logic          ref_rdreq,
    output logic          ref_rdack,
    input  logic [AW-1:0] ref_raddr,
    output logic [DW-1:0] ref_rdata,
    input  logic          hst_req,
    input  logic          hst_we,
    input  logic [AW-1:0] hst_addr,
    input  logic [DW-1:0] hst_wdata,
    output logic          hst_ack,
    output logic [DW-1:0] hst_rdata,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata,
    output logic          addr_err,
    input  logic          addr_err_clr
);

    localparam logic [1:0] RDW_LAST = 2'(RD_LAT - 2);

    arb_state_t    state, next_state;
    req_id_t       grant;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          g_err;

    req_id_t       acc_id;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          acc_err;

    logic [1:0]        rdw_cnt;
    logic [RD_LAT-1:0] rd_shift;
    logic [DW-1:0]     rd_data;
    logic [DW-1:0]     ref_hold;
    logic [DW-1:0]     hst_hold;

    fb_arb_pri #(.HST_MAX(HST_MAX)) u_pri (
        .clk     (clk),
        .rst     (rst),
        .arb_en  (state == ST_IDLE),
        .ref_req (ref_rdreq),
        .cap_req (cap_wrreq),
        .hst_req (hst_req),
        .grant   (grant)
    );

    always_comb begin
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        case (grant)
            REQ_REF: g_addr = ref_raddr;
            REQ_CAP: begin
                g_we    = 1'b1;
                g_addr  = cap_waddr;
                g_wdata = cap_wdata;
            end
            REQ_HST: begin
                g_we    = hst_we;
                g_addr  = hst_addr;
                g_wdata = hst_wdata;
            end
            default: ;
        endcase
        g_err = (g_addr > FB_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (grant != REQ_NONE) next_state = g_we ? ST_WR : ST_RD;
            ST_WR:   next_state = ST_GAP;
            ST_RD:   next_state = (RD_LAT == 1) ? ST_ACK : ST_RDW;
            ST_RDW:  if (rdw_cnt == RDW_LAST) next_state = ST_ACK;
            ST_ACK:  next_state = ST_GAP;
            ST_GAP:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Request fields are frozen at grant so requesters may change them freely afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_id    <= REQ_NONE;
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            acc_err   <= 1'b0;
        end else if (grant != REQ_NONE) begin
            acc_id    <= grant;
            acc_we    <= g_we;
            acc_addr  <= g_addr;
            acc_wdata <= g_wdata;
            acc_err   <= g_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (grant != REQ_NONE && g_err) begin
            addr_err <= 1'b1;
        end else if (addr_err_clr) begin
            addr_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != ST_RDW) begin
            rdw_cnt <= 2'd0;
        end else begin
            rdw_cnt <= rdw_cnt + 2'd1;
        end
    end

    // Tracks issued reads so only data belonging to a live access is ever used.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_shift <= '0;
        end else begin
            rd_shift[0] <= (state == ST_RD) && !acc_err;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_shift[i] <= rd_shift[i-1];
            end
        end
    end

    assign rd_data = rd_shift[RD_LAT-1] ? sram_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_hold <= '0;
            hst_hold <= '0;
        end else if (state == ST_ACK) begin
            if (acc_id == REQ_REF) ref_hold <= rd_data;
            if (acc_id == REQ_HST) hst_hold <= rd_data;
        end
    end

    always_comb begin
        sram_cs   = 1'b0;
        sram_we   = 1'b0;
        cap_wrack = 1'b0;
        ref_rdack = 1'b0;
        hst_ack   = 1'b0;
        case (state)
            ST_WR: begin
                sram_cs   = !acc_err;
                sram_we   = !acc_err;
                cap_wrack = (acc_id == REQ_CAP);
                hst_ack   = (acc_id == REQ_HST);
            end
            ST_RD:  sram_cs = !acc_err;
            ST_ACK: begin
                ref_rdack = (acc_id == REQ_REF);
                hst_ack   = (acc_id == REQ_HST);
            end
            default: ;
        endcase
        ref_rdata = ref_rdack ? rd_data : ref_hold;
        hst_rdata = (state == ST_ACK && acc_id == REQ_HST) ? rd_data : hst_hold;
    end

    assign sram_addr  = acc_addr;
    assign sram_wdata = acc_wdata;

endmodule

// File: tb/tb_fb_port_arb.sv
// Directed bench for fb_port_arb with RD_LAT = 2 and a behavioural SRAM.
module tb_fb_port_arb;
    import lcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_wrreq, cap_wrack;
    logic [12:0] cap_waddr;
    logic [7:0]  cap_wdata;
    logic        ref_rdreq, ref_rdack;
    logic [12:0] ref_raddr;
    logic [7:0]  ref_rdata;
    logic        hst_req, hst_we, hst_ack;
    logic [12:0] hst_addr;
    logic [7:0]  hst_wdata, hst_rdata;
    logic        sram_cs, sram_we;
    logic [12:0] sram_addr;
    logic [7:0]  sram_wdata, sram_rdata;
    logic        addr_err, addr_err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    fb_port_arb #(.RD_LAT(2), .HST_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .cap_wrreq(cap_wrreq), .cap_wrack(cap_wrack), .cap_waddr(cap_waddr), .cap_wdata(cap_wdata),
        .ref_rdreq(ref_rdreq), .ref_rdack(ref_rdack), .ref_raddr(ref_raddr), .ref_rdata(ref_rdata),
        .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
        .hst_ack(hst_ack), .hst_rdata(hst_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .addr_err(addr_err), .addr_err_clr(addr_err_clr)
    );

    always #5 clk = ~clk;

    // SRAM model: read data appears two cycles after chip select, junk otherwise.
    logic [7:0] mem [0:8191];
    logic [7:0] rd_pipe0 = 8'hEE;
    logic [7:0] rd_pipe1 = 8'hEE;
    always @(posedge clk) begin
        if (sram_cs && sram_we) mem[sram_addr] <= sram_wdata;
        rd_pipe0 <= (sram_cs && !sram_we) ? mem[sram_addr] : 8'hEE;
        rd_pipe1 <= rd_pipe0;
    end
    assign sram_rdata = rd_pipe1;

    task automatic host_access(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                               output int ack_cyc, output int cs_cnt,
                               output logic [7:0] rd, output logic err1);
        ack_cyc = -1; cs_cnt = 0; rd = '0; err1 = 1'b0;
        hst_we = we; hst_addr = addr; hst_wdata = wd; hst_req = 1'b1;
        for (int c = 0; c < 16 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (sram_cs) cs_cnt++;
            if (c == 1) err1 = addr_err;
            if (hst_ack) begin
                ack_cyc = c;
                rd = hst_rdata;
            end
            @(posedge clk); #1;
        end
        hst_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cap_wrreq = 0; cap_waddr = '0; cap_wdata = '0;
        ref_rdreq = 0; ref_raddr = '0;
        hst_req = 0; hst_we = 0; hst_addr = '0; hst_wdata = '0;
        addr_err_clr = 0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h0100] = 8'h3C;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({sram_cs, sram_we, sram_addr, sram_wdata} !== 23'd0) begin
            n_fail++; $display("[TB] FAIL reset_sram: got %h expected 0", {sram_cs, sram_we, sram_addr, sram_wdata});
        end
        n_tests++;
        if ({cap_wrack, ref_rdack, hst_ack, addr_err} !== 4'd0) begin
            n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", {cap_wrack, ref_rdack, hst_ack, addr_err});
        end
        n_tests++;
        if ({ref_rdata, hst_rdata} !== 16'd0) begin
            n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 0000", {ref_rdata, hst_rdata});
        end
        n_tests++;
        if (dut.state !== ST_IDLE || dut.u_pri.wait_cnt !== 4'd0) begin
            n_fail++; $display("[TB] FAIL reset_fsm: got state %0d cnt %0d expected 0 0", dut.state, dut.u_pri.wait_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_capture();
        int ack_cyc = -1, cs_cyc = -1, cs_cnt = 0;
        logic [12:0] a = '0;
        logic [7:0]  d = '0;
        logic        w = 1'b0;
        cap_waddr = 13'h0028; cap_wdata = 8'hA5; cap_wrreq = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (sram_cs) begin
                cs_cnt++; a = sram_addr; d = sram_wdata; w = sram_we;
                if (cs_cyc < 0) cs_cyc = c;
            end
            if (cap_wrack && ack_cyc < 0) ack_cyc = c;
            @(posedge clk); #1;
            if (c == 0) begin cap_waddr = '0; cap_wdata = '0; end
            if (ack_cyc >= 0) cap_wrreq = 1'b0;
        end
        n_tests++;
        if (ack_cyc !== 1 || cs_cyc !== 1) begin
            n_fail++; $display("[TB] FAIL cap_timing: got ack %0d cs %0d expected 1 1", ack_cyc, cs_cyc);
        end
        n_tests++;
        if (cs_cnt !== 1) begin
            n_fail++; $display("[TB] FAIL cap_single_write: got %0d accesses expected 1", cs_cnt);
        end
        n_tests++;
        if (a !== 13'h0028 || d !== 8'hA5 || w !== 1'b1) begin
            n_fail++; $display("[TB] FAIL cap_fields: got addr %h data %h we %b expected 0028 a5 1", a, d, w);
        end
    endtask

    task automatic test_refresh();
        int ack_cyc = -1, cs_cnt = 0;
        logic [7:0] rd = '0;
        ref_raddr = 13'h0100; ref_rdreq = 1'b1;
        for (int c = 0; c < 12 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (sram_cs) cs_cnt++;
            if (ref_rdack) begin ack_cyc = c; rd = ref_rdata; end
            @(posedge clk); #1;
        end
        ref_rdreq = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ack_cyc !== 3) begin
            n_fail++; $display("[TB] FAIL ref_latency: got %0d expected 3", ack_cyc);
        end
        n_tests++;
        if (rd !== 8'h3C || cs_cnt !== 1) begin
            n_fail++; $display("[TB] FAIL ref_data: got %h cs %0d expected 3c 1", rd, cs_cnt);
        end
        n_tests++;
        if (ref_rdata !== 8'h3C) begin
            n_fail++; $display("[TB] FAIL ref_hold: got %h expected 3c", ref_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int r = -1, k = -1, h = -1;
        logic [7:0] rdat = '0;
        ref_raddr = 13'h0028;
        cap_waddr = 13'h0030; cap_wdata = 8'h11;
        hst_we = 1'b1; hst_addr = 13'h0200; hst_wdata = 8'h77;
        ref_rdreq = 1'b1; cap_wrreq = 1'b1; hst_req = 1'b1;
        for (int c = 0; c < 24 && (r < 0 || k < 0 || h < 0); c++) begin
            @(negedge clk);
            if (ref_rdack && r < 0) begin r = c; rdat = ref_rdata; end
            if (cap_wrack && k < 0) k = c;
            if (hst_ack && h < 0) h = c;
            @(posedge clk); #1;
            if (r >= 0) ref_rdreq = 1'b0;
            if (k >= 0) cap_wrreq = 1'b0;
            if (h >= 0) hst_req = 1'b0;
        end
        ref_rdreq = 1'b0; cap_wrreq = 1'b0; hst_req = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (r !== 3 || k !== 6 || h !== 9) begin
            n_fail++; $display("[TB] FAIL order: got ref %0d cap %0d hst %0d expected 3 6 9", r, k, h);
        end
        n_tests++;
        if (rdat !== 8'hA5) begin
            n_fail++; $display("[TB] FAIL ref_after_cap_write: got %h expected a5", rdat);
        end
    endtask

    task automatic test_starvation();
        int h = -1, ref_acks = 0, cap_acks = 0;
        logic [3:0] cnt10 = '0, cnt_ack = 4'hF;
        ref_raddr = 13'h0100; ref_rdreq = 1'b1;
        cap_waddr = 13'h0040; cap_wdata = 8'h22; cap_wrreq = 1'b1;
        hst_we = 1'b1; hst_addr = 13'h0300; hst_wdata = 8'h5A; hst_req = 1'b1;
        for (int c = 0; c < 40 && h < 0; c++) begin
            @(negedge clk);
            if (c == 10) cnt10 = dut.u_pri.wait_cnt;
            if (ref_rdack) ref_acks++;
            if (cap_wrack) cap_acks++;
            if (hst_ack) begin h = c; cnt_ack = dut.u_pri.wait_cnt; end
            @(posedge clk); #1;
        end
        ref_rdreq = 1'b0; cap_wrreq = 1'b0; hst_req = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_tests++;
        if (h !== 11) begin
            n_fail++; $display("[TB] FAIL starve_ack_cycle: got %0d expected 11", h);
        end
        n_tests++;
        if (ref_acks !== 2 || cap_acks !== 0) begin
            n_fail++; $display("[TB] FAIL starve_prior_grants: got ref %0d cap %0d expected 2 0", ref_acks, cap_acks);
        end
        n_tests++;
        if (cnt10 !== 4'd8 || cnt_ack !== 4'd0) begin
            n_fail++; $display("[TB] FAIL starve_counter: got %0d then %0d expected 8 then 0", cnt10, cnt_ack);
        end
    endtask

    task automatic test_addr_range();
        int ack, cs;
        logic [7:0] rd;
        logic err1;
        host_access(1'b0, 13'h0030, 8'h00, ack, cs, rd, err1);
        n_tests++;
        if (ack !== 3 || cs !== 1 || rd !== 8'h11) begin
            n_fail++; $display("[TB] FAIL host_read: got ack %0d cs %0d data %h expected 3 1 11", ack, cs, rd);
        end
        host_access(1'b1, 13'h12BF, 8'h42, ack, cs, rd, err1);
        n_tests++;
        if (ack !== 1 || cs !== 1 || err1 !== 1'b0) begin
            n_fail++; $display("[TB] FAIL last_addr: got ack %0d cs %0d err %b expected 1 1 0", ack, cs, err1);
        end
        host_access(1'b1, 13'h12C0, 8'h99, ack, cs, rd, err1);
        n_tests++;
        if (ack !== 1 || cs !== 0 || err1 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL over_addr_write: got ack %0d cs %0d err %b expected 1 0 1", ack, cs, err1);
        end
        @(negedge clk);
        n_tests++;
        if (addr_err !== 1'b1) begin
            n_fail++; $display("[TB] FAIL err_sticky: got %b expected 1", addr_err);
        end
        @(posedge clk); #1 addr_err_clr = 1'b1;
        @(posedge clk); #1 addr_err_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (addr_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL err_clear: got %b expected 0", addr_err);
        end
        @(posedge clk); #1 addr_err_clr = 1'b1;
        host_access(1'b0, 13'h1F00, 8'h00, ack, cs, rd, err1);
        addr_err_clr = 1'b0;
        n_tests++;
        if (ack !== 3 || cs !== 0 || rd !== 8'h00 || err1 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL over_addr_read: got ack %0d cs %0d data %h err %b expected 3 0 00 1", ack, cs, rd, err1);
        end
    endtask

    task automatic test_reset_in_rdw();
        int acks = 0;
        ref_raddr = 13'h0100; ref_rdreq = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (dut.state !== ST_RDW) begin
            n_fail++; $display("[TB] FAIL rdw_reached: got state %0d expected %0d", dut.state, ST_RDW);
        end
        rst = 1'b1; ref_rdreq = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({sram_cs, sram_we, sram_addr, sram_wdata, cap_wrack, ref_rdack, hst_ack,
             ref_rdata, hst_rdata, addr_err} !== 43'd0 || dut.state !== ST_IDLE) begin
            n_fail++; $display("[TB] FAIL rst_rdw_outputs: got ref_rdata %h cs %b state %0d expected 00 0 0",
                               ref_rdata, sram_cs, dut.state);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ref_rdack || ref_rdata !== 8'h00) acks++;
        end
        n_tests++;
        if (acks !== 0) begin
            n_fail++; $display("[TB] FAIL rst_late_data: got %0d ack/data cycles expected 0", acks);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_refresh();
        test_back_to_back();
        test_starvation();
        test_addr_range();
        test_reset_in_rdw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
